iterative_divider: RTL

Multi-cycle unsigned integer divider built around a carry-select subtract step. It is the subtract/inverse-arithmetic counterpart to the existing carry-select adder. It accepts a dividend/divisor pair over a valid/ready handshake and produces one quotient bit per cycle by restoring division. It returns quotient and remainder over a second valid/ready handshake. It sits beside the adder in the FP32 datapath and serves mantissa division and normalisation.

---
 rtl/div_pkg.sv | 20 ++
 rtl/block_subtractor.sv | 39 +++
 rtl/iterative_divider.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM state encoding and sizing helpers.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Carry-select block size for an adder that is adder_w bits wide.
  function automatic int blk_size(input int adder_w);
    return (adder_w < 2) ? 1 : $clog2(adder_w);
  endfunction

  // Step-counter width: must hold WIDTH-1.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/block_subtractor.sv
// Carry-select subtractor: diff = a - b computed as a + ~b + 1, borrow = ~carry_out.
module block_subtractor
  import div_pkg::*;
#(
  parameter int WIDTH = 17
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int BLK = blk_size(WIDTH);
  localparam int NB  = (WIDTH + BLK - 1) / BLK;

  logic [WIDTH-1:0] nb_s;
  logic [NB:0]      c_s;

  assign nb_s   = ~b;
  assign c_s[0] = 1'b1;

  // Each block precomputes both carry-in outcomes; the incoming carry only drives a mux.
  for (genvar i = 0; i < NB; i++) begin : g_blk
    localparam int LO = i * BLK;
    localparam int BW = (LO + BLK > WIDTH) ? (WIDTH - LO) : BLK;

    logic [BW:0] sum0_s;
    logic [BW:0] sum1_s;

    assign sum0_s = {1'b0, a[LO +: BW]} + {1'b0, nb_s[LO +: BW]};
    assign sum1_s = {1'b0, a[LO +: BW]} + {1'b0, nb_s[LO +: BW]} + {{BW{1'b0}}, 1'b1};

    assign diff[LO +: BW] = c_s[i] ? sum1_s[BW-1:0] : sum0_s[BW-1:0];
    assign c_s[i+1]       = c_s[i] ? sum1_s[BW]     : sum0_s[BW];
  end

  assign borrow = ~c_s[NB];

endmodule

// File: rtl/iterative_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock over valid/ready handshakes.
module iterative_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH:0]   r_shift_s;
  logic [WIDTH:0]   trial_s;
  logic             borrow_s;

  // R' = {R[WIDTH-1:0], next dividend bit}; R never exceeds the divisor, so its MSB is always 0.
  assign r_shift_s = (rem_q << 1'b1) | {{WIDTH{1'b0}}, dvd_q[WIDTH-1]};

  block_subtractor #(.WIDTH(WIDTH + 1)) u_sub (
    .a      (r_shift_s),
    .b      ({1'b0, dvs_q}),
    .diff   (trial_s),
    .borrow (borrow_s)
  );

  // Next-state and datapath updates for the IDLE/CALC/DONE sequence.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    quo_d       = quo_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvd_d = dividend;
          dvs_d = divisor;
          if (divisor != {WIDTH{1'b0}}) begin
            rem_d   = {(WIDTH+1){1'b0}};
            cnt_d   = CNT_LOAD;
            dbz_d   = 1'b0;
            state_d = CALC;
          end else begin
            quotient_d  = {WIDTH{1'b1}};
            remainder_d = dividend;
            dbz_d       = 1'b1;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        dvd_d = dvd_q << 1'b1;
        quo_d = (quo_q << 1'b1) | {{(WIDTH-1){1'b0}}, ~borrow_s};
        rem_d = borrow_s ? r_shift_s : trial_s;
        if (cnt_q == {CW{1'b0}}) begin
          quotient_d  = quo_d;
          remainder_d = rem_d[WIDTH-1:0];
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= {CW{1'b0}};
      rem_q       <= {(WIDTH+1){1'b0}};
      dvd_q       <= {WIDTH{1'b0}};
      dvs_q       <= {WIDTH{1'b0}};
      quo_q       <= {WIDTH{1'b0}};
      quotient_q  <= {WIDTH{1'b0}};
      remainder_q <= {WIDTH{1'b0}};
      dbz_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      quo_q       <= quo_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = out_valid_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule
